cache_line_reader: RTL and testbench
====================================

Name: cache_line_reader

Overview:
- Reads one complete cache line out of the cache data RAM through its read port and streams it as words on a valid/ready interface.
- Used on the cache writeback (eviction) path, and by any block that must drain a line to the memory bus.
- The RAM read port has a registered address and unregistered data, so read data is valid one cycle after the address is presented.
- This block is the reader counterpart of the RAM write path.

Parameters:
- WIDTH, 32, data word width; must match the data RAM.
- DEPTH, 1024, data RAM depth in words; ADDR_WIDTH = ceil(log2(DEPTH)).
- LINE_WORDS, 8, words per cache line; power of two, at least 2. LINE_BITS = log2(LINE_WORDS).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request to read a line; sampled only when busy=0.
- lineIndex  in  ADDR_WIDTH-LINE_BITS  line to read; captured when start is accepted.
- busy  out  1  a line transfer is in progress.
- done  out  1  one-cycle pulse when a line transfer completes.
- ramReadAddress  out  ADDR_WIDTH  read address to the data RAM; equals {line, word}.
- ramReadData  in  WIDTH  RAM read data; valid the cycle after the address.
- outValid  out  1  outData is valid.
- outReady  in  1  downstream accepts the word.
- outData  out  WIDTH  line word.
- outLast  out  1  marks the final word of the line; qualified by outValid.

Behaviour:
- Reset values: busy=0, done=0, outValid=0, outLast=0, outData=0, ramReadAddress=0.
- A reset mid-transfer aborts the transfer. Buffered and in-flight words are discarded, and all outputs take their reset values on the next cycle.
- FSM states:
  - IDLE: start=1 captures lineIndex, clears the issue and pop counters, and moves to RUN. busy=1 from the next cycle.
  - RUN: issues reads and pops words. After the handshake of the outLast word, moves to DONE.
  - DONE: one cycle with done=1 and busy=0, then returns to IDLE. start is accepted in the DONE cycle and behaves exactly as in IDLE.
- start is ignored while busy=1.
- Issue rule:
  - One RAM address per cycle, in order word 0..LINE_WORDS-1.
  - An address is issued only if (buffered entries + in-flight read) < 2, or == 2 while a pop occurs in the same cycle.
  - The output buffer holds 2 entries.
  - No word is ever dropped or overwritten under any outReady pattern.
  - When no address is issued, ramReadAddress holds its last value.
- Data capture: the read issued in cycle N is written into the buffer at the end of cycle N+1.
- Output:
  - outData, outValid and outLast come directly from the buffer head registers.
  - A pop occurs when outValid=1 and outReady=1.
  - outValid=1 and outData must stay stable until the pop.
- Latency: start accepted in cycle C → first address in C+1 → outValid=1 in C+2.
- Throughput: with outReady held at 1, one word per cycle. The last word is popped at C+LINE_WORDS+1, and done=1 at C+LINE_WORDS+2.
- outLast=1 only on the LINE_WORDS-th word popped.
- Counters are LINE_BITS+1 bits wide. The word offset wraps modulo LINE_WORDS.

Optional Feature:
- CACHE_LINE_READER_WRAP_EN (critical-word-first ordering).
- Defined:
  - Adds port startWord  in  LINE_BITS, captured with lineIndex.
  - Read order is startWord, startWord+1, …, wrapping modulo LINE_WORDS, for LINE_WORDS words in total.
  - outLast is on word (startWord-1) mod LINE_WORDS.
- Not defined:
  - startWord does not exist.
  - Order is always 0..LINE_WORDS-1.
- Timing and handshake rules are identical in both cases.

Test Plan:
- Streaming: LINE_WORDS=8, lineIndex=5, outReady=1, start in cycle C → ramReadAddress 40..47 in C+1..C+8; outValid in C+2..C+9 with the RAM contents of 40..47 in order; outLast only at C+9; done=1 at C+10.
- Backpressure: outReady=0 for words 3..6, then 1 → all 8 words delivered in order with no loss; outData stable while stalled; ramReadAddress advances at most 2 words past the last popped word.
- start pulsed while busy with lineIndex=9 → ignored; the current line completes unchanged, and no read of line 9 is issued.
- rst=1 after 3 words popped → outValid, busy and done are 0 the next cycle; a new start on line 2 reads addresses 16..23 from word 0.
- Back-to-back: start asserted in the done cycle with lineIndex=1 → addresses 8..15 follow with the same C+1 / C+2 latency.
- With CACHE_LINE_READER_WRAP_EN, startWord=6, lineIndex=0 → order 6,7,0,1,2,3,4,5; outLast on word 5.

Source files
------------

// File: rtl/cache_line_reader.sv
// cache_line_reader
//
// Reads one whole cache line out of the cache data RAM and streams it as
// words on a valid/ready interface. It is used on the writeback (eviction)
// path and by any block that drains a line to the memory bus.
//
// The RAM is modelled as registered address / unregistered data. The address
// register is ramReadAddress itself. A read is issued in cycle N when that
// register is loaded at the end of N. The RAM data is valid in cycle N+1 and
// is written into the output buffer at the end of N+1.
//
// Build option:
//   CACHE_LINE_READER_WRAP_EN  critical-word-first ordering. When defined,
//   this adds the startWord port. Words are then read from startWord upward,
//   wrapping modulo LINE_WORDS. When not defined, words are always read
//   0..LINE_WORDS-1.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           line request, sampled only while busy=0
//   lineIndex       line to read, captured with start
//   startWord       first word of the line (wrap build only)
//   busy            transfer in progress
//   done            one-cycle pulse after the last word is handed over
//   ramReadAddress  RAM read address {line, word}
//   ramReadData     RAM read data, valid the cycle after an issue
//   outValid/outReady/outData/outLast  output word stream
//   fsmState        current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a word transfers on any rising edge where outValid=1 and
// outReady=1. Once outValid is raised, outValid, outData and outLast hold
// until that transfer. outValid never depends combinationally on outReady.
module cache_line_reader #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int LINE_WORDS = 8,
    localparam int ADDR_WIDTH  = $clog2(DEPTH),
    localparam int LINE_BITS   = $clog2(LINE_WORDS),
    localparam int INDEX_WIDTH = ADDR_WIDTH - LINE_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] lineIndex,
`ifdef CACHE_LINE_READER_WRAP_EN
    input  logic [LINE_BITS-1:0]   startWord,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  ramReadAddress,
    input  logic [WIDTH-1:0]       ramReadData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [WIDTH-1:0]       outData,
    output logic                   outLast,
    output logic [1:0]             fsmState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [LINE_BITS:0] LINE_COUNT = (LINE_BITS + 1)'(LINE_WORDS);
    localparam logic [LINE_BITS:0] LAST_INDEX = (LINE_BITS + 1)'(LINE_WORDS - 1);
    localparam logic [LINE_BITS:0] COUNT_ONE  = (LINE_BITS + 1)'(1);

    stateT                  state;
    logic [INDEX_WIDTH-1:0] lineReg;
    logic [LINE_BITS-1:0]   baseWord;     // first word of the line order
    logic [LINE_BITS:0]     issueCount;   // reads issued so far
    logic [LINE_BITS:0]     popCount;     // words handed downstream so far
    logic                   inFlight;     // a read was issued last cycle
    logic                   inFlightLast; // that read is the final word

    // Two-entry output buffer. The head entry drives the outputs directly.
    logic                   headValid;
    logic                   headLast;
    logic [WIDTH-1:0]       headData;
    logic                   tailValid;
    logic                   tailLast;
    logic [WIDTH-1:0]       tailData;

    logic [LINE_BITS-1:0]   reqWord;
    logic                   pop;
    logic                   accept;
    logic                   issue;
    logic [1:0]             occupancy;
    logic [LINE_BITS-1:0]   issueWord;

`ifdef CACHE_LINE_READER_WRAP_EN
    assign reqWord = startWord;
`else
    assign reqWord = '0;
`endif

    always_comb begin
        pop       = headValid && outReady;
        accept    = start && (state != RUN);
        occupancy = {1'b0, headValid} + {1'b0, tailValid} + {1'b0, inFlight};
        // Buffered plus in-flight words never exceed the two buffer entries,
        // so the captured read always has a free slot.
        issue     = (state == RUN) && (issueCount < LINE_COUNT) &&
                    ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
        // Truncation to LINE_BITS gives the modulo-LINE_WORDS wrap.
        issueWord = issueCount[LINE_BITS-1:0] + baseWord;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            ramReadAddress <= '0;
            lineReg        <= '0;
            baseWord       <= '0;
            issueCount     <= '0;
            popCount       <= '0;
            inFlight       <= 1'b0;
            inFlightLast   <= 1'b0;
            headValid      <= 1'b0;
            headLast       <= 1'b0;
            headData       <= '0;
            tailValid      <= 1'b0;
            tailLast       <= 1'b0;
            tailData       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        // The first word is issued in the accept cycle.
                        // This makes the address visible in C+1 and the data
                        // visible in C+2.
                        state          <= RUN;
                        busy           <= 1'b1;
                        lineReg        <= lineIndex;
                        baseWord       <= reqWord;
                        ramReadAddress <= {lineIndex, reqWord};
                        issueCount     <= COUNT_ONE;
                        popCount       <= '0;
                        inFlight       <= 1'b1;
                        inFlightLast   <= 1'b0;
                    end
                end

                RUN: begin
                    inFlight <= issue;
                    if (issue) begin
                        ramReadAddress <= {lineReg, issueWord};
                        issueCount     <= issueCount + COUNT_ONE;
                        inFlightLast   <= (issueCount == LAST_INDEX);
                    end

                    if (pop) begin
                        popCount <= popCount + COUNT_ONE;
                        if (popCount == LAST_INDEX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end

                    if (inFlight) begin
                        if (pop) begin
                            if (tailValid) begin
                                headData <= tailData;
                                headLast <= tailLast;
                                tailData <= ramReadData;
                                tailLast <= inFlightLast;
                            end else begin
                                headData <= ramReadData;
                                headLast <= inFlightLast;
                            end
                        end else if (headValid) begin
                            tailValid <= 1'b1;
                            tailData  <= ramReadData;
                            tailLast  <= inFlightLast;
                        end else begin
                            headValid <= 1'b1;
                            headData  <= ramReadData;
                            headLast  <= inFlightLast;
                        end
                    end else if (pop) begin
                        headValid <= tailValid;
                        headData  <= tailData;
                        headLast  <= tailLast;
                        tailValid <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign outValid = headValid;
    assign outData  = headData;
    assign outLast  = headLast;
    assign fsmState = state;

endmodule

// File: tb/tb_cache_line_reader.sv
module tb_cache_line_reader;
    localparam int WIDTH      = 32;
    localparam int DEPTH      = 1024;
    localparam int LINE_WORDS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        outReady = 1'b1;
    logic [6:0]  lineIndex = '0;
`ifdef CACHE_LINE_READER_WRAP_EN
    logic [2:0]  startWord = '0;
`endif
    logic        busy;
    logic        done;
    logic        outValid;
    logic        outLast;
    logic [9:0]  ramReadAddress;
    logic [31:0] ramReadData;
    logic [31:0] outData;
    logic [1:0]  fsmState;

    int total = 0;
    int bad = 0;
    int popTotal = 0;
    int lineBase = 0;
    bit prevStall = 1'b0;
    bit boundOn = 1'b0;
    logic [31:0] prevData = '0;

    logic [WIDTH-1:0] exp_q[$];
    logic             expLast_q[$];

    typedef struct {
        logic [6:0]  line;
        logic [2:0]  sw;
        logic [15:0] mask;
        bit          rnd;
        logic [9:0]  expFirst;
        logic [9:0]  expLast;
        int          expLatency;
    } vec_t;

    vec_t vecs[$];

    // Distinct, address-derived RAM contents.
    function automatic logic [31:0] ramWord(input logic [9:0] a);
        return {a[7:0] ^ 8'h5A, 6'b0, a, ~a[7:0]};
    endfunction

    assign ramReadData = ramWord(ramReadAddress);

    cache_line_reader #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .LINE_WORDS(LINE_WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .lineIndex(lineIndex),
`ifdef CACHE_LINE_READER_WRAP_EN
        .startWord(startWord),
`endif
        .busy(busy),
        .done(done),
        .ramReadAddress(ramReadAddress),
        .ramReadData(ramReadData),
        .outValid(outValid),
        .outReady(outReady),
        .outData(outData),
        .outLast(outLast),
        .fsmState(fsmState)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Scoreboard side: sample on the falling edge, pop expected on handshake.
    task automatic sample();
        @(negedge clk);
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                check("stall_valid", 32'(outValid), 32'd1);
                check("stall_data", outData, prevData);
            end
            if (boundOn && busy)
                check("issue_ahead", 32'(int'(ramReadAddress[2:0]) <= (popTotal - lineBase + 1)), 32'd1);
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want none", outData);
                end else begin
                    check("out_data", outData, exp_q.pop_front());
                    check("out_last", 32'(outLast), 32'(expLast_q.pop_front()));
                end
                popTotal++;
            end
            prevStall = outValid && !outReady;
            prevData  = outData;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Driver: raise start and push the words the line must produce.
    task automatic driveStart(input logic [6:0] line, input logic [2:0] sw);
        start     = 1'b1;
        lineIndex = line;
`ifdef CACHE_LINE_READER_WRAP_EN
        startWord = sw;
`endif
        lineBase  = popTotal;
        for (int i = 0; i < LINE_WORDS; i++) begin
            logic [2:0] w;
            w = sw + 3'(i);
            exp_q.push_back(ramWord({line, w}));
            expLast_q.push_back(i == LINE_WORDS - 1);
        end
    endtask

    // Runs one line. k counts cycles after the start cycle C.
    // On return the bench sits in the done cycle.
    task automatic runTransfer(input logic [6:0] line, input logic [2:0] sw,
                               input logic [15:0] mask, input bit rnd, input bit inDoneCycle,
                               output int latency, output logic [9:0] firstA,
                               output logic [9:0] lastA, output int firstValid);
        if (!inDoneCycle) advance();
        driveStart(line, sw);
        if (!inDoneCycle) sample();
        advance();
        start = 1'b0;
        latency = -1;
        firstValid = -1;
        firstA = '0;
        lastA = '0;
        for (int k = 1; k < 120; k++) begin
            outReady = rnd ? 1'($urandom_range(0, 1)) : ((k < 16) ? mask[k] : 1'b1);
            sample();
            if (k == 1) firstA = ramReadAddress;
            lastA = ramReadAddress;
            if (outValid && firstValid < 0) firstValid = k;
            if (done) begin
                latency = k;
                break;
            end
            advance();
        end
        outReady = 1'b1;
        check("done_seen", 32'(latency >= 0), 32'd1);
    endtask

    initial begin
        int lat;
        int fv;
        int stalls;
        logic [9:0] fa;
        logic [9:0] la;

        vecs.push_back('{7'd5,   3'd0, 16'hFFFF, 1'b0, 10'd40,   10'd47,   10});
        vecs.push_back('{7'd0,   3'd0, 16'hFFFF, 1'b0, 10'd0,    10'd7,    10});
        vecs.push_back('{7'd127, 3'd0, 16'hFFFF, 1'b0, 10'd1016, 10'd1023, 10});
        vecs.push_back('{7'd3,   3'd0, 16'hFFF3, 1'b0, 10'd24,   10'd31,   12});
        vecs.push_back('{7'd9,   3'd0, 16'h0001, 1'b0, 10'd72,   10'd79,   24});
        vecs.push_back('{7'd126, 3'd0, 16'hAAAA, 1'b0, 10'd1008, 10'd1015, 17});
        vecs.push_back('{7'd7,   3'd0, 16'h0000, 1'b1, 10'd56,   10'd63,   0});
`ifdef CACHE_LINE_READER_WRAP_EN
        vecs.push_back('{7'd0,   3'd6, 16'hFFFF, 1'b0, 10'd6,    10'd5,    10});
        vecs.push_back('{7'd4,   3'd3, 16'hFFF3, 1'b0, 10'd35,   10'd34,   12});
`endif

        // Reset values.
        rst = 1'b1;
        advance();
        advance();
        sample();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_last", 32'(outLast), 32'd0);
        check("rst_data", outData, 32'd0);
        check("rst_addr", 32'(ramReadAddress), 32'd0);
        rst = 1'b0;

        // Cycle-exact streaming of line 5.
        advance();
        driveStart(7'd5, 3'd0);
        sample();
        advance();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            sample();
            if (k <= 8) check("stream_addr", 32'(ramReadAddress), 32'(40 + k - 1));
            check("stream_valid", 32'(outValid), 32'(k >= 2 && k <= 9));
            check("stream_last", 32'(outLast), 32'(k == 9));
            check("stream_done", 32'(done), 32'(k == 10));
            check("stream_busy", 32'(busy), 32'(k <= 9));
            if (k < 10) advance();
        end

        // Table of whole-line transfers.
        for (int i = 0; i < vecs.size(); i++) begin
            runTransfer(vecs[i].line, vecs[i].sw, vecs[i].mask, vecs[i].rnd, 1'b0, lat, fa, la, fv);
            check("first_addr", 32'(fa), 32'(vecs[i].expFirst));
            check("last_addr", 32'(la), 32'(vecs[i].expLast));
            check("first_valid", 32'(fv), 32'd2);
            if (vecs[i].expLatency != 0) check("latency", 32'(lat), 32'(vecs[i].expLatency));
            check("drained", 32'(exp_q.size()), 32'd0);
        end

        // Back-to-back: start in the done cycle of the previous line.
        runTransfer(7'd5, 3'd0, 16'hFFFF, 1'b0, 1'b0, lat, fa, la, fv);
        check("b2b_done_cycle", 32'(done), 32'd1);
        runTransfer(7'd1, 3'd0, 16'hFFFF, 1'b0, 1'b1, lat, fa, la, fv);
        check("b2b_first_addr", 32'(fa), 32'd8);
        check("b2b_last_addr", 32'(la), 32'd15);
        check("b2b_first_valid", 32'(fv), 32'd2);
        check("b2b_latency", 32'(lat), 32'd10);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: three words popped, then four stalled cycles.
        advance();
        driveStart(7'd4, 3'd0);
        boundOn = 1'b1;
        sample();
        advance();
        start = 1'b0;
        stalls = 0;
        lat = -1;
        for (int k = 1; k < 60; k++) begin
            outReady = !((popTotal - lineBase >= 3) && (stalls < 4));
            if (!outReady) stalls++;
            sample();
            if (done) begin
                lat = k;
                break;
            end
            advance();
        end
        outReady = 1'b1;
        boundOn = 1'b0;
        check("bp_latency", 32'(lat), 32'd14);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // start while busy with line 9 is ignored.
        advance();
        driveStart(7'd5, 3'd0);
        sample();
        advance();
        start = 1'b0;
        lat = -1;
        for (int k = 1; k < 60; k++) begin
            if (k == 3 || k == 4) begin
                start = 1'b1;
                lineIndex = 7'd9;
            end else begin
                start = 1'b0;
            end
            sample();
            check("no_line9_read", 32'(ramReadAddress[9:3] != 7'd9), 32'd1);
            if (done) begin
                lat = k;
                break;
            end
            advance();
        end
        start = 1'b0;
        check("busy_start_latency", 32'(lat), 32'd10);
        check("busy_start_drained", 32'(exp_q.size()), 32'd0);
        advance();
        sample();
        check("busy_start_no_restart", 32'(busy), 32'd0);

        // Reset after three words of line 6.
        advance();
        driveStart(7'd6, 3'd0);
        sample();
        advance();
        start = 1'b0;
        for (int k = 1; k < 40; k++) begin
            sample();
            if (popTotal - lineBase >= 3) break;
            advance();
        end
        check("pre_rst_pops", 32'(popTotal - lineBase), 32'd3);
        advance();
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
        sample();
        check("mid_rst_valid", 32'(outValid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_addr", 32'(ramReadAddress), 32'd0);
        exp_q.delete();
        expLast_q.delete();
        runTransfer(7'd2, 3'd0, 16'hFFFF, 1'b0, 1'b0, lat, fa, la, fv);
        check("post_rst_first_addr", 32'(fa), 32'd16);
        check("post_rst_last_addr", 32'(la), 32'd23);
        check("post_rst_latency", 32'(lat), 32'd10);
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
